serial_adder_ctrl: RTL

Bit-serial adder sequencer built around the lab's single-bit `fadder` cell (`btn1`/`btn2`/`btn3` in, `led0`/`led1` out).
- Accepts two WIDTH-bit operands and a carry-in through a start/done handshake.
- Drives one `fadder` instance LSB-first, one bit per clock, keeping the running carry in a register.
- Presents the registered WIDTH-bit sum and carry-out when finished.
- Sits between the board-level operand/button logic and the LED/result display.

---
 rtl/serial_adder_ctrl_if.sv | 27 ++
 rtl/serial_adder_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - start/done operand and result bundle for the serial adder
// Ports (master = requester, slave = adder):
//   start, a, b, cin : request and operands, driven by the master
//   busy, done       : status, driven by the slave
//   sum, cout        : registered result, driven by the slave
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencer around a single-bit fadder cell
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : serial_adder_ctrl_if.slave (start/a/b/cin in, busy/done/sum/cout out)

// Single-bit full adder cell: led0 = sum bit, led1 = carry out.
module fadder (
  input  logic btn1,
  input  logic btn2,
  input  logic btn3,
  output logic led0,
  output logic led1
);
  assign led0 = btn1 ^ btn2 ^ btn3;
  assign led1 = (btn1 & btn2) | (btn1 & btn3) | (btn2 & btn3);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] psum_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             led0;
  logic             led1;
  logic             last_bit;

  fadder u_fadder (
    .btn1 (a_sh[0]),
    .btn2 (b_sh[0]),
    .btn3 (carry),
    .led0 (led0),
    .led1 (led1)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // New sum bit enters at the MSB; after WIDTH shifts bit i holds sum bit i.
  // Written as shift-then-overwrite so WIDTH=1 needs no special case.
  always_comb begin
    psum_d            = psum >> 1;
    psum_d[WIDTH-1]   = led0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_bit)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      psum   <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
            psum  <= '0;
          end
        end
        RUN: begin
          psum  <= psum_d;
          carry <= led1;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + CW'(1);
          // Result registers only move on completion so sum/cout hold between operations.
          if (last_bit) begin
            sum_q  <= psum_d;
            cout_q <= led1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule
